mdu_e: RTL

Multiply/divide unit for the E stage of the pipelined MIPS core. It sits beside the ALU, accepts mult/multu/div/divu/mthi/mtlo operations, and runs multi-cycle multiply and divide against private operand latches. It owns the HI/LO registers and reports a busy condition that the hazard unit uses to stall HI/LO-dependent instructions in D.

---
 rtl/mdu_e.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/mdu_e.sv
// E-stage multiply/divide unit: owns HI/LO, runs multi-cycle mult/div on latched
// operands and raises Busy/MDstall so HI/LO readers in D wait for the result.
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic [2:0]  MDop,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic        Busy,
  output logic        MDstall
);

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_BITS   = $clog2(MAX_CYCLES + 1);
  localparam int CNT_W      = (CNT_BITS < 4) ? 4 : CNT_BITS;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      a_q, b_q;
  md_op_t           op_q;
  logic [31:0]      hi_q, lo_q;

  md_op_t      md_op;
  logic        start_op;
  logic        start;
  logic        finish;

  logic        hi_we, lo_we;
  logic [31:0] hi_d, lo_d;

  logic        res_we;
  logic [31:0] res_hi, res_lo;

  assign md_op    = md_op_t'(MDop);
  assign start_op = (md_op == MD_MULT) || (md_op == MD_MULTU) ||
                    (md_op == MD_DIV)  || (md_op == MD_DIVU);
  assign start    = (state_q == IDLE) && start_op;
  assign finish   = (state_q == RUN) && (cnt_q == CNT_W'(1));

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (hi_we) hi_q <= hi_d;
      if (lo_we) lo_q <= lo_d;
    end
  end

  // NOTE: operand latches carry no reset; they are only consumed in RUN, which
  // is always entered through a load, so a reset would just cost fanout.
  always_ff @(posedge clk) begin
    if (start) begin
      a_q  <= SrcA;
      b_q  <= SrcB;
      op_q <= md_op;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal driven here gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = ((md_op == MD_MULT) || (md_op == MD_MULTU)) ?
                    CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (finish) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs and HI/LO write control
  // ---------------------------------------------------------------------------
  always_comb begin
    Busy    = (state_q == RUN);
    MDstall = Busy || start_op;
    hi_we   = 1'b0;
    lo_we   = 1'b0;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == IDLE) begin
      if (md_op == MD_MTHI) begin
        hi_we = 1'b1;
        hi_d  = SrcA;
      end
      if (md_op == MD_MTLO) begin
        lo_we = 1'b1;
        lo_d  = SrcA;
      end
    end else if (finish && res_we) begin
      hi_we = 1'b1;
      lo_we = 1'b1;
      hi_d  = res_hi;
      lo_d  = res_lo;
    end
  end

  assign HI = hi_q;
  assign LO = lo_q;

  // ---------------------------------------------------------------------------
  // Datapath on latched operands: one shared multiplier and one shared divider
  // ---------------------------------------------------------------------------
  logic        op_signed;
  logic [63:0] mul_a, mul_b, product;
  logic [31:0] dvd_mag, dvs_mag, quo_mag, rem_mag;
  logic [31:0] quo, rem;
  logic        div_by_zero;

  assign op_signed = (op_q == MD_MULT) || (op_q == MD_DIV);

  // Sign-extended 64x64 product truncated to 64 bits equals the signed product.
  assign mul_a   = {(op_signed ? {32{a_q[31]}} : 32'h0), a_q};
  assign mul_b   = {(op_signed ? {32{b_q[31]}} : 32'h0), b_q};
  assign product = mul_a * mul_b;

  // Signed divide runs on magnitudes, then fixes signs: quotient truncates
  // toward zero, remainder follows the dividend. 0x80000000/-1 wraps naturally.
  assign dvd_mag     = (op_signed && a_q[31]) ? (32'h0 - a_q) : a_q;
  assign dvs_mag     = (op_signed && b_q[31]) ? (32'h0 - b_q) : b_q;
  assign div_by_zero = (b_q == 32'h0);
  assign quo_mag     = div_by_zero ? 32'h0 : (dvd_mag / dvs_mag);
  assign rem_mag     = div_by_zero ? 32'h0 : (dvd_mag % dvs_mag);
  assign quo         = (op_signed && (a_q[31] ^ b_q[31])) ? (32'h0 - quo_mag) : quo_mag;
  assign rem         = (op_signed && a_q[31]) ? (32'h0 - rem_mag) : rem_mag;

  always_comb begin
    res_we = 1'b0;
    res_hi = 32'h0;
    res_lo = 32'h0;
    unique case (op_q)
      MD_MULT, MD_MULTU: begin
        res_we = 1'b1;
        res_hi = product[63:32];
        res_lo = product[31:0];
      end
      MD_DIV, MD_DIVU: begin
        res_we = !div_by_zero;
        res_hi = rem;
        res_lo = quo;
      end
      default: res_we = 1'b0;
    endcase
  end

endmodule
